// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble, one digit corrected per clock).
// Optional nibble range check with o_Error is enabled by defining BCD_TO_BINARY_ERR_EN.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
    input  logic                          i_Start,
    output logic [OUTPUT_WIDTH-1:0]       o_Binary,
    output logic                          o_DV,
    output logic                          o_Busy
`ifdef BCD_TO_BINARY_ERR_EN
    ,
    output logic                          o_Error
`endif
);

    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int CNT_W = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECIMAL_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUTPUT_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE              = 3'd0,
        SHIFT             = 3'd1,
        CHECK_SHIFT_INDEX = 3'd2,
        SUB               = 3'd3,
        CHECK_DIGIT_INDEX = 3'd4,
        DONE              = 3'd5
    } state_t;

    state_t                  r_State;
    logic [BCD_W-1:0]        r_BCD;
    logic [OUTPUT_WIDTH-1:0] r_Bin;
    logic [CNT_W-1:0]        r_Loop;
    logic [IDX_W-1:0]        r_Digit;
    logic [OUTPUT_WIDTH-1:0] r_Binary;
    logic                    r_DV;
    logic                    r_Busy;
    logic [BCD_W-1:0]        w_BCD_Sub;

    // Only the digit selected by r_Digit is corrected; MSB set means the digit is >= 8.
    always_comb begin
        w_BCD_Sub = r_BCD;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (IDX_W'(i) == r_Digit && r_BCD[i*4+3]) begin
                w_BCD_Sub[i*4 +: 4] = r_BCD[i*4 +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_TO_BINARY_ERR_EN
    logic r_Err_Flag;
    logic r_Error;
    logic w_Bad_Nibble;

    // A nibble is above 9 when bit 3 is set together with bit 2 or bit 1.
    always_comb begin
        w_Bad_Nibble = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (i_BCD[i*4+3] && (i_BCD[i*4+2] || i_BCD[i*4+1])) begin
                w_Bad_Nibble = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Err_Flag <= 1'b0;
            r_Error    <= 1'b0;
        end else if (r_State == IDLE && i_Start) begin
            r_Err_Flag <= w_Bad_Nibble;
        end else if (r_State == DONE) begin
            r_Error <= r_Err_Flag;
        end
    end

    assign o_Error = r_Error;
`endif

    // Handshake: i_Start is a request taken only in IDLE (including the cycle o_DV is high);
    // o_DV is a one-cycle, unstalled result strobe with no back-pressure.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State  <= IDLE;
            r_BCD    <= '0;
            r_Bin    <= '0;
            r_Loop   <= '0;
            r_Digit  <= '0;
            r_Binary <= '0;
            r_DV     <= 1'b0;
            r_Busy   <= 1'b0;
        end else begin
            case (r_State)
                IDLE: begin
                    r_DV <= 1'b0;
                    if (i_Start) begin
                        r_BCD   <= i_BCD;
                        r_Bin   <= '0;
                        r_Busy  <= 1'b1;
                        r_State <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_BCD, r_Bin} <= {1'b0, r_BCD, r_Bin[OUTPUT_WIDTH-1:1]};
                    r_State        <= CHECK_SHIFT_INDEX;
                end
                CHECK_SHIFT_INDEX: begin
                    if (r_Loop == LAST_CNT) begin
                        r_Loop  <= '0;
                        r_State <= DONE;
                    end else begin
                        r_Loop  <= r_Loop + 1'b1;
                        r_State <= SUB;
                    end
                end
                SUB: begin
                    r_BCD   <= w_BCD_Sub;
                    r_State <= CHECK_DIGIT_INDEX;
                end
                CHECK_DIGIT_INDEX: begin
                    if (r_Digit == LAST_IDX) begin
                        r_Digit <= '0;
                        r_State <= SHIFT;
                    end else begin
                        r_Digit <= r_Digit + 1'b1;
                        r_State <= SUB;
                    end
                end
                DONE: begin
`ifdef BCD_TO_BINARY_ERR_EN
                    r_Binary <= r_Err_Flag ? '0 : r_Bin;
`else
                    r_Binary <= r_Bin;
`endif
                    r_DV     <= 1'b1;
                    r_Busy   <= 1'b0;
                    r_State  <= IDLE;
                end
                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

    assign o_Binary = r_Binary;
    assign o_DV     = r_DV;
    assign o_Busy   = r_Busy;

endmodule
